// File: rtl/dac_threshold_spi_if.sv
// Threshold DAC link bundle: controller-side request/response plus SPI pins.
// master = measure controller, slave = dac_threshold_spi.
interface dac_threshold_spi_if;
  logic [15:0] threshold_i;
  logic        threshold_wre_i;
  logic        threshold_rdy_o;
  logic        busy_o;
  logic [15:0] last_code_o;
  logic        spi_cs_n_o;
  logic        spi_sclk_o;
  logic        spi_mosi_o;

  modport master (
    output threshold_i, threshold_wre_i,
    input  threshold_rdy_o, busy_o, last_code_o,
    input  spi_cs_n_o, spi_sclk_o, spi_mosi_o
  );

  modport slave (
    input  threshold_i, threshold_wre_i,
    output threshold_rdy_o, busy_o, last_code_o,
    output spi_cs_n_o, spi_sclk_o, spi_mosi_o
  );
endinterface

// File: rtl/dac_threshold_spi.sv
// Threshold DAC writer: serialises {DAC_CMD, code} over mode-0 SPI,
// waits for settling, then pulses threshold_rdy_o.
// Ports: clk_i, arst_i (async, active-low), bus (slave modport):
//   threshold_i/threshold_wre_i in; threshold_rdy_o, busy_o,
//   last_code_o, spi_cs_n_o, spi_sclk_o, spi_mosi_o out.
// Option: DAC_SKIP_SAME_EN skips the SPI write for a repeated code.
module dac_threshold_spi #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter logic [7:0]  DAC_CMD       = 8'h30
) (
  input logic               clk_i,
  input logic               arst_i,
  dac_threshold_spi_if.slave bus
);
  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_DIV);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, CS_HOLD, SETTLE, DONE
  } state_t;

  state_t        state;
  logic [23:0]   shreg;
  logic [15:0]   code_q;
  logic [15:0]   pend_code;
  logic          pend;
  logic [CW-1:0] div_cnt;
  logic [4:0]    rise_cnt;
  logic [SW-1:0] set_cnt;
  logic          rdy_q;
  logic          busy_q;
  logic          cs_n_q;
  logic          sclk_q;
  logic          mosi_q;
  logic [15:0]   last_q;

  logic        wre;
  logic        set_end;
  logic        ld_go;
  logic        skip_go;
  logic [15:0] ld_code;

  assign wre     = bus.threshold_wre_i;
  assign set_end = (state == SETTLE) && (set_cnt == SET_LAST);
  assign ld_code = pend ? pend_code : bus.threshold_i;

`ifdef DAC_SKIP_SAME_EN
  logic wrote_q;
  assign skip_go = (state == IDLE) && wre && !pend && wrote_q &&
                   (bus.threshold_i == last_q);
`else
  assign skip_go = 1'b0;
`endif

  // A queued code starts on the edge that raises rdy, so
  // back-to-back transfers are spaced by exactly one latency.
  assign ld_go = !skip_go && (wre || pend) &&
                 ((state == IDLE) || (state == DONE) || set_end);

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state     <= IDLE;
      shreg     <= '0;
      code_q    <= '0;
      pend_code <= '0;
      pend      <= 1'b0;
      div_cnt   <= '0;
      rise_cnt  <= '0;
      set_cnt   <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      last_q    <= '0;
`ifdef DAC_SKIP_SAME_EN
      wrote_q   <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b0;
      if (wre) pend_code <= bus.threshold_i;
      // A write landing on a load edge stays queued behind it.
      if (ld_go) pend <= pend && wre;
      else if (wre && !skip_go) pend <= 1'b1;

      unique case (state)
        IDLE, DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (skip_go) begin
            busy_q  <= 1'b1;
            set_cnt <= SET_LAST;
            state   <= SETTLE;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk_q) begin
              sclk_q   <= 1'b1;
              rise_cnt <= rise_cnt + 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (rise_cnt == 5'd24) begin
                mosi_q <= 1'b0;
                state  <= CS_HOLD;
              end else begin
                shreg  <= {shreg[22:0], 1'b0};
                mosi_q <= shreg[22];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        CS_HOLD: begin
          if (div_cnt == HOLD_LAST) begin
            cs_n_q  <= 1'b1;
            last_q  <= code_q;
            set_cnt <= '0;
            state   <= SETTLE;
`ifdef DAC_SKIP_SAME_EN
            wrote_q <= 1'b1;
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (set_end) begin
            rdy_q <= 1'b1;
            state <= DONE;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (ld_go) begin
        code_q   <= ld_code;
        shreg    <= {DAC_CMD, ld_code};
        mosi_q   <= DAC_CMD[7];
        cs_n_q   <= 1'b0;
        sclk_q   <= 1'b0;
        busy_q   <= 1'b1;
        div_cnt  <= '0;
        rise_cnt <= '0;
        state    <= SHIFT;
      end
    end
  end

  assign bus.threshold_rdy_o = rdy_q;
  assign bus.busy_o          = busy_q;
  assign bus.last_code_o     = last_q;
  assign bus.spi_cs_n_o      = cs_n_q;
  assign bus.spi_sclk_o      = sclk_q;
  assign bus.spi_mosi_o      = mosi_q;
endmodule
